// File: rtl/ascon_pack.sv
// Shared ASCON datapath types: the 5 x 64-bit permutation state and the
// control enum for the iterative substitution layer.
package ascon_pack;

    localparam int NB_COLUMNS = 64;
    localparam int NB_ROWS    = 5;
    localparam int COL_W      = $clog2(NB_COLUMNS);

    // Element 0 is x0 and occupies the most significant 64 bits.
    typedef logic [0:NB_ROWS-1][NB_COLUMNS-1:0] type_state;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } type_sbox_layer_fsm;

endpackage

// File: rtl/sbox.sv
// ASCON 5-bit S-box, bit-sliced form; sbox_i[4] carries x0.
module sbox (
    input  logic [4:0] sbox_i,
    output logic [4:0] sbox_o
);

    logic a0, a1, a2, a3, a4;
    logic b0, b1, b2, b3, b4;

    always_comb begin
        a0 = sbox_i[4] ^ sbox_i[0];
        a1 = sbox_i[3];
        a2 = sbox_i[2] ^ sbox_i[3];
        a3 = sbox_i[1];
        a4 = sbox_i[0] ^ sbox_i[1];

        // chi-like nonlinear step
        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);

        sbox_o[4] = b0 ^ b4;
        sbox_o[3] = b1 ^ b0;
        sbox_o[2] = ~b2;
        sbox_o[1] = b3 ^ b2;
        sbox_o[0] = b4;
    end

endmodule

// File: rtl/sbox_layer_iter.sv
// Iterative ASCON substitution layer: LANES bit-columns of the captured state
// go through the S-box each cycle; result returned over valid/ready.
module sbox_layer_iter
    import ascon_pack::*;
#(
    parameter int LANES = 8
) (
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      clear_i,
    input  logic      in_valid_i,
    output logic      in_ready_o,
    input  type_state state_i,
    output logic      out_valid_o,
    input  logic      out_ready_i,
    output type_state state_o
);

    localparam int NB_ITER = NB_COLUMNS / LANES;
    localparam int CNT_W   = (NB_ITER > 1) ? $clog2(NB_ITER) : 1;
    localparam int LANE_SH = $clog2(LANES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB_ITER - 1);

    type_sbox_layer_fsm fsm_q, fsm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    type_state          in_q, in_d;
    type_state          res_q, res_d;

    logic [COL_W-1:0]   base;
    logic [4:0]         lane_out [LANES];

    // First column handled this cycle; zero-extension covers LANES=64.
    assign base = COL_W'(cnt_q) << LANE_SH;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [COL_W-1:0] col;
        logic [4:0]       s_in;
        logic [4:0]       s_out;

        assign col  = base + COL_W'(l);
        assign s_in = {in_q[0][col], in_q[1][col], in_q[2][col], in_q[3][col], in_q[4][col]};

        sbox u_sbox (
            .sbox_i(s_in),
            .sbox_o(s_out)
        );

        assign lane_out[l] = s_out;
    end

    always_comb begin
        logic [COL_W-1:0] col_w;
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        in_d  = in_q;
        res_d = res_q;
        col_w = '0;

        if (clear_i) begin
            fsm_d = IDLE;
            cnt_d = '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        in_d  = state_i;
                        cnt_d = '0;
                        fsm_d = RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        col_w = base + COL_W'(l);
                        for (int k = 0; k < NB_ROWS; k++) begin
                            res_d[k][col_w] = lane_out[l][4-k];
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        fsm_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        fsm_d = IDLE;
                    end
                end
                default: begin
                    fsm_d = IDLE;
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            in_q  <= '0;
            res_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            in_q  <= in_d;
            res_q <= res_d;
        end
    end

    // Outputs decode registered state only.
    assign in_ready_o  = (fsm_q == IDLE);
    assign out_valid_o = (fsm_q == DONE);
    assign state_o     = res_q;

endmodule

// File: tb/tb_sbox_layer_iter.sv
// Bench for sbox_layer_iter: three instances (LANES = 8, 1, 64) sharing clock,
// reset and clear; expected states queued at drive time, popped at output.
module tb_sbox_layer_iter;
    import ascon_pack::*;

    localparam logic [4:0] SBOX_TAB [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic      clk;
    logic      resetb;
    logic      clear;
    logic      in_valid  [3];
    logic      in_ready  [3];
    logic      out_valid [3];
    logic      out_ready [3];
    type_state st_in     [3];
    type_state st_out    [3];

    type_state exp_q [$];
    int        n_checks;
    int        n_fail;

    sbox_layer_iter #(.LANES(8)) dut_l8 (
        .clock_i(clk), .resetb_i(resetb), .clear_i(clear),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .state_i(st_in[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .state_o(st_out[0])
    );

    sbox_layer_iter #(.LANES(1)) dut_l1 (
        .clock_i(clk), .resetb_i(resetb), .clear_i(clear),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .state_i(st_in[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .state_o(st_out[1])
    );

    sbox_layer_iter #(.LANES(64)) dut_l64 (
        .clock_i(clk), .resetb_i(resetb), .clear_i(clear),
        .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]), .state_i(st_in[2]),
        .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .state_o(st_out[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic type_state model(input type_state s);
        type_state  r;
        logic [4:0] v;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            v = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            v = SBOX_TAB[v];
            for (int k = 0; k < 5; k++) r[k][j] = v[4-k];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input int d, input type_state s);
        @(negedge clk);
        check("in_ready_before_start", 320'(in_ready[d]), 320'(1));
        in_valid[d] = 1'b1;
        st_in[d]    = s;
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, input int exp_lat);
        int n;
        n = 0;
        while (!out_valid[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("latency", 320'(n), 320'(exp_lat));
    endtask

    task automatic txn(input int d, input type_state s, input type_state e, input int lat);
        type_state got;
        start(d, s);
        exp_q.push_back(e);
        wait_out(d, lat);
        got = exp_q.pop_front();
        check("state_out", st_out[d], got);
        @(negedge clk);
        check("idle_after_consume", 320'({in_ready[d], out_valid[d]}), 320'(2'b10));
    endtask

    initial begin
        type_state zero_s, ones_s, cols_s, pat_s, snap, e;
        logic [4:0] v;

        n_checks = 0;
        n_fail   = 0;
        resetb   = 1'b0;
        clear    = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            st_in[d]     = '0;
        end

        zero_s = '0;
        ones_s = '1;
        for (int j = 0; j < 64; j++) begin
            v = 5'(j % 32);
            for (int k = 0; k < 5; k++) cols_s[k][j] = v[4-k];
        end
        pat_s = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'hdeadbeefcafef00d,
                 64'h5555aaaa3333cccc, 64'h0f0f0f0ff0f0f0f0};

        #1;
        check("reset_in_ready",  320'(in_ready[0]),  320'(1));
        check("reset_out_valid", 320'(out_valid[0]), 320'(0));
        check("reset_state_o",   st_out[0], 320'(0));
        repeat (2) @(negedge clk);
        resetb = 1'b1;

        // All-zero and all-ones states on LANES=8.
        txn(0, zero_s, {64'h0, 64'h0, 64'hffffffffffffffff, 64'h0, 64'h0}, 8);
        txn(0, ones_s, {64'hffffffffffffffff, 64'h0, 64'hffffffffffffffff,
                        64'hffffffffffffffff, 64'hffffffffffffffff}, 8);

        // Every S-box input value, across all three lane counts.
        txn(0, cols_s, model(cols_s), 8);
        txn(1, cols_s, model(cols_s), 64);
        txn(2, cols_s, model(cols_s), 1);
        txn(2, pat_s,  model(pat_s),  1);

        // Backpressure in DONE with an ignored in_valid pulse.
        out_ready[0] = 1'b0;
        start(0, pat_s);
        wait_out(0, 8);
        snap = st_out[0];
        e    = model(pat_s);
        check("bp_state", snap, e);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid[0] = (i == 2);
            st_in[0]    = ~pat_s;
            check("bp_out_valid", 320'(out_valid[0]), 320'(1));
            check("bp_in_ready",  320'(in_ready[0]),  320'(0));
            check("bp_stable",    st_out[0], snap);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release_idle", 320'({in_ready[0], out_valid[0]}), 320'(2'b10));
        @(negedge clk);
        check("bp_no_capture", 320'({in_ready[0], out_valid[0]}), 320'(2'b10));

        // Abort during RUN, then a clean transaction.
        start(0, cols_s);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("abort_idle", 320'({in_ready[0], out_valid[0]}), 320'(2'b10));
        txn(0, zero_s, {64'h0, 64'h0, 64'hffffffffffffffff, 64'h0, 64'h0}, 8);

        // Asynchronous reset between clock edges mid-RUN.
        start(0, ones_s);
        repeat (2) @(negedge clk);
        #2;
        resetb = 1'b0;
        #1;
        check("async_in_ready",  320'(in_ready[0]),  320'(1));
        check("async_out_valid", 320'(out_valid[0]), 320'(0));
        check("async_state_o",   st_out[0], 320'(0));
        @(negedge clk);
        resetb = 1'b1;
        txn(0, cols_s, model(cols_s), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
